// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for one single-port RAM.
//
// Requests from A and B are serialised onto the RAM port one at a time. Each access
// takes three states (ACCESS, RESP, then the next IDLE decision), so at most one
// access completes every three cycles. All RAM-side outputs and all acks and read
// data come from registers.
//
// Optional feature: define ARB_CLEAR_EN to build the background clear sweep.
// Without it, clr_start is ignored and clr_busy is tied low.
//
// Parameters:
//   ADDR_W    RAM address width; the array holds 2**ADDR_W words
//   DATA_W    RAM data width
//
// Ports:
//   clk       clock; all logic runs on its rising edge
//   rst       synchronous active-high reset
//   a_req     A request; held with a_we/a_addr/a_wdata stable until a_ack
//   a_we      A direction, 1 = write, 0 = read
//   a_addr    A address
//   a_wdata   A write data
//   a_ack     A completion pulse, one cycle
//   a_rdata   A read data, valid in the a_ack cycle of a read
//   b_*       same as the A ports, for requester B
//   clr_start one-cycle pulse that requests a clear sweep
//   clr_busy  high while a clear sweep runs
//   mem_wren  RAM write enable
//   mem_addr  RAM address
//   mem_wdata RAM write data
//   mem_rdata RAM read data

module ram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,

  input  logic              clr_start,
  output logic              clr_busy,

  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
`ifdef ARB_CLEAR_EN
    ,
    StClear
`endif
  } state_e;

  state_e            state_q;
  logic              rr_q;         // 0: A wins a tie, 1: B wins a tie
  logic              win_q;        // requester owning the current access, 0 = A
  logic              mem_wren_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

`ifdef ARB_CLEAR_EN
  logic              clr_pend_q;
  logic              clr_busy_q;
`else
  logic              unused_clr_start;
  assign unused_clr_start = clr_start;
`endif

  // A takes the grant when it is the only requester or when it holds the tie-break.
  logic a_wins;
  assign a_wins = a_req && (!b_req || !rr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      win_q       <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef ARB_CLEAR_EN
      clr_pend_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
`endif
    end else begin
      // Acks are single-cycle pulses; only the ACCESS exit raises one.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;

`ifdef ARB_CLEAR_EN
      // A start seen during a sweep is dropped rather than queued for a second sweep.
      if (clr_start && (state_q != StClear)) begin
        clr_pend_q <= 1'b1;
      end
`endif

      case (state_q)
        StIdle: begin
`ifdef ARB_CLEAR_EN
          // A pending clear pre-empts both requesters, which then wait for the sweep.
          if (clr_pend_q || clr_start) begin
            clr_pend_q  <= 1'b0;
            clr_busy_q  <= 1'b1;
            mem_wren_q  <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            state_q     <= StClear;
          end else
`endif
          if (a_req || b_req) begin
            win_q       <= !a_wins;
            rr_q        <= a_wins;    // tie-break passes to the loser
            mem_wren_q  <= a_wins ? a_we    : b_we;
            mem_addr_q  <= a_wins ? a_addr  : b_addr;
            mem_wdata_q <= a_wins ? a_wdata : b_wdata;
            state_q     <= StAccess;
          end
        end

        StAccess: begin
          // RAM read data is valid while the address is presented, so capture it here.
          if (!mem_wren_q) begin
            if (win_q) begin
              b_rdata_q <= mem_rdata;
            end else begin
              a_rdata_q <= mem_rdata;
            end
          end
          if (win_q) begin
            b_ack_q <= 1'b1;
          end else begin
            a_ack_q <= 1'b1;
          end
          mem_wren_q <= 1'b0;         // port idles as a read of the held address
          state_q    <= StResp;
        end

        // Ack is high for this state; the following IDLE cycle gives the requester
        // time to drop or replace its request before the next decision.
        StResp: begin
          state_q <= StIdle;
        end

`ifdef ARB_CLEAR_EN
        StClear: begin
          if (mem_addr_q == '1) begin
            clr_busy_q <= 1'b0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= StIdle;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
          end
        end
`endif

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_CLEAR_EN
  assign clr_busy = clr_busy_q;
`else
  assign clr_busy = 1'b0;
`endif

endmodule
